param_seq_alu: RTL and testbench

PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

---
 rtl/param_seq_alu.sv | 196 +++++++++++++++++++
 tb/tb_param_seq_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/param_seq_alu.sv
// param_seq_alu: sequential ALU with a bit-serial shifter.
// Non-shift ops complete one cycle after an accepted start. Shifts move the
// working register one bit per cycle for n = min(b, WIDTH) cycles. The result
// and the {carry, overflow, negative, zero} flags are registered and hold their
// value until the next operation completes.
module param_seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_LIMIT = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    N_MAX   = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        OP_CLR = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_SHL = 3'b011,
        OP_SHR = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e           r_state;
    state_e           w_next_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_work;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    op_e              w_op_in;
    logic             w_is_shift;
    logic [CW-1:0]    w_n;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic             w_alu_ovf;
    logic [3:0]       w_alu_flags;
    logic [WIDTH-1:0] w_shift_work;
    logic             w_shift_out;
    logic             w_last_shift;
    logic             w_busy;
    logic             w_done;

    assign w_op_in    = op_e'(op);
    assign w_is_shift = (w_op_in == OP_SHL) || (w_op_in == OP_SHR);
    // Shift counts saturate at WIDTH: any larger count leaves the same all-zero result.
    assign w_n        = (b >= W_LIMIT) ? N_MAX : b[CW-1:0];
    assign w_sum      = {1'b0, a} + {1'b0, b};
    assign w_diff     = {1'b0, a} - {1'b0, b};
    assign w_last_shift = (r_cnt <= CNT_ONE);

    // Single-cycle result and flags for the non-shift opcodes, from the live inputs.
    always_comb begin
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        w_alu_ovf    = 1'b0;
        case (w_op_in)
            OP_CLR: w_alu_result = '0;
            OP_ADD: begin
                w_alu_result = w_sum[WIDTH-1:0];
                w_alu_carry  = w_sum[WIDTH];
                w_alu_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_result = w_diff[WIDTH-1:0];
                w_alu_carry  = w_diff[WIDTH];
                w_alu_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_alu_result = a & b;
            OP_OR:  w_alu_result = a | b;
            OP_XOR: w_alu_result = a ^ b;
            default: w_alu_result = '0;
        endcase
        w_alu_flags = {w_alu_carry, w_alu_ovf, w_alu_result[WIDTH-1], (w_alu_result == '0)};
    end

    // One-bit shift step of the working register, plus the bit that falls out.
    always_comb begin
        w_shift_work = '0;
        w_shift_out  = 1'b0;
        if (r_op == OP_SHL) begin
            w_shift_work = {r_work[WIDTH-2:0], 1'b0};
            w_shift_out  = r_work[WIDTH-1];
        end else begin
            w_shift_work = {1'b0, r_work[WIDTH-1:1]};
            w_shift_out  = r_work[0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // A zero-length shift skips SHIFT so it still completes in one cycle.
                    if (w_is_shift && (w_n != '0)) begin
                        w_next_state = S_SHIFT;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (w_last_shift) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_done = (r_state == S_DONE);
    end

    // Operand capture, shift counter/working register and registered result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_CLR;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= w_op_in;
                        r_work <= a;
                        if (w_is_shift) begin
                            r_cnt <= w_n;
                            if (w_n == '0) begin
                                r_result <= a;
                                r_flags  <= {1'b0, 1'b0, a[WIDTH-1], (a == '0)};
                            end
                        end else begin
                            r_result <= w_alu_result;
                            r_flags  <= w_alu_flags;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_shift_work;
                    r_cnt  <= r_cnt - CNT_ONE;
                    // The final shift is written straight to the result so done follows n shift edges.
                    if (w_last_shift) begin
                        r_result <= w_shift_work;
                        r_flags  <= {w_shift_out, 1'b0, w_shift_work[WIDTH-1], (w_shift_work == '0)};
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign flags  = r_flags;
    assign busy   = w_busy;
    assign done   = w_done;

endmodule

// File: tb/tb_param_seq_alu.sv
// tb_param_seq_alu: directed vector table plus hand-written multi-cycle sequences
// for param_seq_alu at WIDTH=32.
module tb_param_seq_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  op = '0;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    param_seq_alu #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result),
        .busy   (busy),
        .done   (done),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one start pulse and waits (bounded) for done; returns at the negedge where done is high.
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output logic busy_ok);
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        bok;
        int          dcount;
        logic [31:0] captured;
        logic        saw_done;

        //            op      a             b             result        flags    lat
        vecs[0]  = '{3'b001, 32'd21,       32'd10,       32'd31,       4'b0000, 1};
        vecs[1]  = '{3'b010, 32'd9,        32'd54,       32'hFFFFFFD3, 4'b1010, 1};
        vecs[2]  = '{3'b010, 32'd54,       32'd9,        32'd45,       4'b0000, 1};
        vecs[3]  = '{3'b001, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b0110, 1};
        vecs[4]  = '{3'b001, 32'hFFFFFFFF, 32'd1,        32'h00000000, 4'b1001, 1};
        vecs[5]  = '{3'b000, 32'd5,        32'd6,        32'h00000000, 4'b0001, 1};
        vecs[6]  = '{3'b101, 32'hF0,       32'h3C,       32'h30,       4'b0000, 1};
        vecs[7]  = '{3'b110, 32'hF0,       32'h0F,       32'hFF,       4'b0000, 1};
        vecs[8]  = '{3'b111, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 4'b0000, 1};
        vecs[9]  = '{3'b010, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b0100, 1};
        vecs[10] = '{3'b011, 32'd10,       32'd3,        32'd80,       4'b0000, 4};
        vecs[11] = '{3'b100, 32'h80000000, 32'd40,       32'h00000000, 4'b1001, 33};
        vecs[12] = '{3'b011, 32'd5,        32'd0,        32'd5,        4'b0000, 1};
        vecs[13] = '{3'b100, 32'hFF,       32'd4,        32'h0F,       4'b1000, 5};
        vecs[14] = '{3'b011, 32'h80000001, 32'd1,        32'h00000002, 4'b1000, 2};
        vecs[15] = '{3'b011, 32'hC0000000, 32'd1,        32'h80000000, 4'b1010, 2};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_flags",  {28'h0, flags}, 32'h0);
        check("reset_busy",   {31'h0, busy}, 32'h0);
        check("reset_done",   {31'h0, done}, 32'h0);
        rst = 1'b0;

        // Vector table.
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_while_running", i), {31'h0, bok}, 32'h1);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_flags", i), {28'h0, flags}, {28'h0, vecs[i].flg});
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), {31'h0, done}, 32'h0);
            check($sformatf("v%0d_idle_after", i), {31'h0, busy}, 32'h0);
        end

        // Idle with start low holds result/flags regardless of inputs.
        op = 3'b001; a = 32'h1234; b = 32'h1;
        repeat (4) @(negedge clk);
        check("hold_result", result, 32'h80000000);
        check("hold_flags", {28'h0, flags}, 32'hA);

        // Start pulsed mid-shift is ignored: one done, result 80.
        @(negedge clk);
        op = 3'b011; a = 32'd10; b = 32'd3; start = 1'b1;
        @(negedge clk);
        op = 3'b001; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        captured = '0;
        for (int k = 0; k < 10; k++) begin
            if (done) begin
                dcount++;
                captured = result;
            end
            @(negedge clk);
        end
        check("midshift_start_done_count", dcount, 1);
        check("midshift_start_result", captured, 32'd80);
        check("midshift_start_result_held", result, 32'd80);
        check("midshift_start_idle", {31'h0, busy}, 32'h0);

        // Reset at cycle 5 of a 20-bit shift aborts it with no done pulse.
        @(negedge clk);
        op = 3'b100; a = 32'hFF; b = 32'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_done = 1'b0;
        for (int k = 1; k < 5; k++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_no_done", {31'h0, saw_done | done}, 32'h0);
        check("abort_result", result, 32'h0);
        check("abort_flags", {28'h0, flags}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        // First start presented on the edge right after reset deasserts.
        rst = 1'b0;
        op = 3'b101; a = 32'hF0; b = 32'h3C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_reset_done", {31'h0, done}, 32'h1);
        check("post_reset_result", result, 32'h30);
        check("post_reset_flags", {28'h0, flags}, 32'h0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1; op = 3'b001; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_over_start_busy", {31'h0, busy}, 32'h0);
        check("rst_over_start_result", result, 32'h0);
        @(negedge clk);
        check("rst_over_start_no_done", {31'h0, done}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
